snow64_instr_fetch: RTL and testbench

SNOW64_INSTR_FETCH -- requirements
Module: snow64_instr_fetch

---
 rtl/snow64_instr_fetch_pkg.sv | 48 ++++
 rtl/snow64_instr_fetch.sv | 106 ++++++++++
 tb/tb_snow64_instr_fetch.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snow64_instr_fetch_pkg.sv
// Shared types for the instruction-fetch stage: CPU address/instruction
// widths, the fetch FSM state, and the partial port bundles on the cache
// side and the decode side.
package PkgSnow64InstrFetch;

  // CPU-wide widths; addresses are instruction indices, not byte addresses.
  localparam int WIDTH__ADDR  = 64;
  localparam int WIDTH__INSTR = 32;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StHold,
    StDrain
  } State;

  // Redirect strobe coming from branch/jump resolution.
  typedef struct packed {
    logic                   valid;
    logic [WIDTH__ADDR-1:0] addr;
  } PartialPortInRedirect;

  // Instruction-cache response.
  typedef struct packed {
    logic                    valid;
    logic [WIDTH__INSTR-1:0] instr;
  } PartialPortInIcache;

  // Instruction-cache read request.
  typedef struct packed {
    logic                   req;
    logic [WIDTH__ADDR-1:0] addr;
  } PartialPortOutIcache;

  // Decode-side acceptance.
  typedef struct packed {
    logic ready;
  } PartialPortInDecode;

  // Instruction offered to decode.
  typedef struct packed {
    logic                    valid;
    logic [WIDTH__INSTR-1:0] instr;
    logic [WIDTH__ADDR-1:0]  pc;
  } PartialPortOutDecode;

endpackage

// File: rtl/snow64_instr_fetch.sv
// Instruction fetch: issues one instruction-cache read at a time, parks the
// returned word for decode, and follows branch/jump redirects.
//
// Handshake: decode sees an instruction while out_valid is high; out_instr and
// out_pc stay stable until a cycle where in_ready is high (transfer) or a
// redirect arrives. The cache sees a single-cycle out_icache_req pulse and
// answers later with a single-cycle in_icache_valid; only one request is ever
// outstanding. A request whose target was redirected away is drained (its
// response swallowed) before the next request is issued.
module snow64_instr_fetch
  import PkgSnow64InstrFetch::*;
#(
  parameter logic [WIDTH__ADDR-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_redirect_valid,
  input  logic [WIDTH__ADDR-1:0]  in_redirect_addr,
  output logic                    out_icache_req,
  output logic [WIDTH__ADDR-1:0]  out_icache_addr,
  input  logic                    in_icache_valid,
  input  logic [WIDTH__INSTR-1:0] in_icache_instr,
  output logic                    out_valid,
  output logic [WIDTH__INSTR-1:0] out_instr,
  output logic [WIDTH__ADDR-1:0]  out_pc,
  input  logic                    in_ready
);

  localparam logic [WIDTH__ADDR-1:0] PcStep = WIDTH__ADDR'(1);

  State                 state;
  logic [WIDTH__ADDR-1:0] pc;
  logic                 req_q;
  PartialPortOutDecode  decode_q;
  PartialPortInRedirect redirect;
  PartialPortInIcache   icache_in;
  PartialPortInDecode   decode_in;
  PartialPortOutIcache  icache_out;

  assign redirect   = '{valid: in_redirect_valid, addr: in_redirect_addr};
  assign icache_in  = '{valid: in_icache_valid, instr: in_icache_instr};
  assign decode_in  = '{ready: in_ready};
  // The request address is the live pc register; pc only moves in StReq on
  // a redirect, and that request is then drained.
  assign icache_out = '{req: req_q, addr: pc};

  assign out_icache_req  = icache_out.req;
  assign out_icache_addr = icache_out.addr;
  assign out_valid       = decode_q.valid;
  assign out_instr       = decode_q.instr;
  assign out_pc          = decode_q.pc;

  // Fetch FSM: state, pc and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      pc       <= RESET_PC;
      req_q    <= 1'b0;
      decode_q <= '0;
    end else begin
      req_q <= 1'b0;
      if (redirect.valid) begin
        pc <= redirect.addr;
      end
      case (state)
        StIdle: begin
          state <= StReq;
          req_q <= 1'b1;
        end
        StReq: begin
          // The request just issued is in flight; a redirect must drain it.
          state <= redirect.valid ? StDrain : StWait;
        end
        StWait: begin
          if (redirect.valid) begin
            state <= StDrain;
          end else if (icache_in.valid) begin
            decode_q.valid <= 1'b1;
            decode_q.instr <= icache_in.instr;
            decode_q.pc    <= pc;
            pc             <= pc + PcStep;
            state          <= StHold;
          end
        end
        StHold: begin
          // A redirect retires the offer whether or not decode took it.
          if (redirect.valid || decode_in.ready) begin
            decode_q.valid <= 1'b0;
            state          <= StReq;
            req_q          <= 1'b1;
          end
        end
        StDrain: begin
          if (icache_in.valid) begin
            state <= StReq;
            req_q <= 1'b1;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snow64_instr_fetch.sv
// Bench for snow64_instr_fetch: a cache responder, a transaction-level model of
// what fetch must request and offer, directed scenarios and a random run.
module tb_snow64_instr_fetch;

  localparam logic [63:0] RESET_PC = 64'h10;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_addr;
  logic        icache_req;
  logic [63:0] icache_addr;
  logic        cache_valid;
  logic [31:0] cache_instr;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        ready;

  always #5 clk = ~clk;

  snow64_instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_redirect_valid(redirect_valid),
    .in_redirect_addr (redirect_addr),
    .out_icache_req   (icache_req),
    .out_icache_addr  (icache_addr),
    .in_icache_valid  (cache_valid),
    .in_icache_instr  (cache_instr),
    .out_valid        (out_valid),
    .out_instr        (out_instr),
    .out_pc           (out_pc),
    .in_ready         (ready)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int offers = 0;

  // Reference model: address the next request must carry, the request in
  // flight, whether it is still wanted, and the word the cache returned.
  logic [63:0] exp_next;
  logic [63:0] req_addr;
  logic [31:0] resp_word;
  bit          live;
  bit          pending;
  int          countdown;
  int          delay_cfg = 2;
  bit          resp_real;
  bit          spurious_en;
  bit          force_en;
  logic [31:0] force_word;
  bit          prev_valid;
  logic [31:0] prev_instr;
  logic [63:0] prev_pc;

  // One clock: apply inputs, observe after the edge, update model, pick the
  // cache response for the next edge.
  task automatic step();
    bit          rst_a;
    bit          redir_a;
    bit          ready_a;
    bit          resp_a;
    bit          new_req;
    logic [63:0] raddr_a;
    rst_a   = rst;
    redir_a = redirect_valid;
    raddr_a = redirect_addr;
    ready_a = ready;
    resp_a  = resp_real;
    new_req = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_a) begin
      exp_next = RESET_PC;
      live     = 1'b0;
      pending  = 1'b0;
    end else begin
      if (redir_a) begin
        // A reply landing on the same edge as the first redirect is thrown
        // away, so fetch still waits for one more reply before refetching.
        if (resp_a && live) begin
          pending   = 1'b1;
          countdown = 3;
        end
        exp_next = raddr_a;
        live     = 1'b0;
      end
      if (prev_valid && (ready_a || redir_a)) begin
        vectors++;
        if (out_valid !== 1'b0 || icache_req !== 1'b1)
          begin miscompares++; $display("FAIL handoff: valid=%0b req=%0b, need valid=0 req=1", out_valid, icache_req); end
      end else if (prev_valid) begin
        vectors++;
        if (out_valid !== 1'b1 || out_instr !== prev_instr || out_pc !== prev_pc || icache_req !== 1'b0)
          begin miscompares++; $display("FAIL hold_stable: valid=%0b instr=%h pc=%h req=%0b, need 1 %h %h 0", out_valid, out_instr, out_pc, icache_req, prev_instr, prev_pc); end
      end else if (out_valid) begin
        vectors++;
        offers++;
        if (!live || pending || out_pc !== req_addr || out_instr !== resp_word)
          begin miscompares++; $display("FAIL offer: pc=%h instr=%h live=%0b, need pc=%h instr=%h live=1", out_pc, out_instr, live, req_addr, resp_word); end
        exp_next = out_pc + 64'd1;
        live     = 1'b0;
      end
      if (icache_req) begin
        vectors++;
        if (icache_addr !== exp_next || pending)
          begin miscompares++; $display("FAIL request: addr=%h outstanding=%0b, need addr=%h outstanding=0", icache_addr, pending, exp_next); end
        req_addr  = icache_addr;
        live      = 1'b1;
        pending   = 1'b1;
        countdown = delay_cfg;
        new_req   = 1'b1;
      end
    end
    prev_valid  = out_valid;
    prev_instr  = out_instr;
    prev_pc     = out_pc;
    cache_valid = 1'b0;
    resp_real   = 1'b0;
    cache_instr = $urandom;
    if (pending && !new_req) begin
      countdown--;
      if (countdown <= 0) begin
        resp_word   = force_en ? force_word : $urandom;
        cache_instr = resp_word;
        cache_valid = 1'b1;
        resp_real   = 1'b1;
        pending     = 1'b0;
      end
    end else if (!pending && spurious_en && out_valid && $urandom_range(0, 3) == 0) begin
      cache_valid = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b need 0", out_valid); end
    vectors++; if (icache_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %0b need 0", icache_req); end
    vectors++; if (out_instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h need 0", out_instr); end
    vectors++; if (out_pc !== 64'h0) begin miscompares++; $display("FAIL reset_pc: got %h need 0", out_pc); end
    rst = 1'b0;
    step();
    vectors++;
    if (icache_req !== 1'b1 || icache_addr !== RESET_PC)
      begin miscompares++; $display("FAIL first_req: req=%0b addr=%h need 1 %h", icache_req, icache_addr, RESET_PC); end
  endtask

  task automatic test_sequential();
    logic [63:0] pcs[$];
    int          when[$];
    ready = 1'b1;
    for (int i = 0; i < 40 && pcs.size() < 3; i++) begin
      step();
      if (out_valid) begin pcs.push_back(out_pc); when.push_back(cyc); end
    end
    vectors++;
    if (pcs.size() != 3) begin miscompares++; $display("FAIL seq_count: got %0d offers need 3", pcs.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (pcs[i] !== RESET_PC + 64'(i)) begin miscompares++; $display("FAIL seq_pc%0d: got %h need %h", i, pcs[i], RESET_PC + 64'(i)); end
      end
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (when[i+1] - when[i] != 4) begin miscompares++; $display("FAIL seq_period%0d: got %0d need 4", i, when[i+1] - when[i]); end
      end
    end
  endtask

  task automatic test_hit_latency();
    int t_req;
    delay_cfg = 1;
    ready = 1'b1;
    step();
    for (int i = 0; i < 20 && !icache_req; i++) step();
    t_req = cyc;
    for (int i = 0; i < 20 && !out_valid; i++) step();
    vectors++;
    if (cyc - t_req != 2 || out_valid !== 1'b1)
      begin miscompares++; $display("FAIL hit_latency: got %0d cycles valid=%0b need 2", cyc - t_req, out_valid); end
  endtask

  task automatic test_backpressure();
    logic [63:0] held_pc;
    bit          bad;
    ready = 1'b1;
    step();
    for (int i = 0; i < 20 && !icache_req; i++) step();
    force_en   = 1'b1;
    force_word = 32'hDEADBEEF;
    ready      = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) step();
    vectors++;
    if (out_valid !== 1'b1 || out_instr !== 32'hDEADBEEF)
      begin miscompares++; $display("FAIL bp_offer: valid=%0b instr=%h need 1 deadbeef", out_valid, out_instr); end
    held_pc = out_pc;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_valid !== 1'b1 || out_instr !== 32'hDEADBEEF || out_pc !== held_pc || icache_req !== 1'b0) bad = 1'b1;
    end
    vectors++;
    if (bad) begin miscompares++; $display("FAIL bp_stall: valid=%0b instr=%h pc=%h req=%0b need 1 deadbeef %h 0", out_valid, out_instr, out_pc, icache_req, held_pc); end
    ready = 1'b1;
    step();
    vectors++;
    if (out_valid !== 1'b0 || icache_req !== 1'b1 || icache_addr !== held_pc + 64'd1)
      begin miscompares++; $display("FAIL bp_release: valid=%0b req=%0b addr=%h need 0 1 %h", out_valid, icache_req, icache_addr, held_pc + 64'd1); end
    force_en = 1'b0;
  endtask

  task automatic test_redirect_miss();
    bit saw_valid;
    int t_redir;
    delay_cfg = 9;
    ready = 1'b1;
    step();
    for (int i = 0; i < 20 && !icache_req; i++) step();
    delay_cfg = 1;
    step();
    redirect_valid = 1'b1;
    redirect_addr  = 64'h400;
    step();
    t_redir = cyc;
    redirect_valid = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 20 && !icache_req; i++) begin
      if (out_valid) saw_valid = 1'b1;
      step();
    end
    vectors++;
    if (saw_valid || icache_req !== 1'b1 || icache_addr !== 64'h400 || cyc - t_redir < 8)
      begin miscompares++; $display("FAIL miss_redirect: stale=%0b req=%0b addr=%h after %0d, need 0 1 400 >=8", saw_valid, icache_req, icache_addr, cyc - t_redir); end
    for (int i = 0; i < 20 && !out_valid; i++) step();
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 64'h400)
      begin miscompares++; $display("FAIL miss_target: valid=%0b pc=%h need 1 400", out_valid, out_pc); end
  endtask

  task automatic test_simultaneous();
    bit saw_valid;
    delay_cfg = 1;
    ready = 1'b1;
    step();
    for (int i = 0; i < 20 && !icache_req; i++) step();
    for (int i = 0; i < 20 && !(cache_valid && resp_real); i++) step();
    redirect_valid = 1'b1;
    redirect_addr  = 64'h80;
    step();
    redirect_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || icache_req !== 1'b0)
      begin miscompares++; $display("FAIL simul_drop: valid=%0b req=%0b need 0 0", out_valid, icache_req); end
    saw_valid = 1'b0;
    for (int i = 0; i < 20 && !icache_req; i++) begin
      step();
      if (out_valid) saw_valid = 1'b1;
    end
    vectors++;
    if (saw_valid || icache_req !== 1'b1 || icache_addr !== 64'h80)
      begin miscompares++; $display("FAIL simul_refetch: stale=%0b req=%0b addr=%h need 0 1 80", saw_valid, icache_req, icache_addr); end
  endtask

  task automatic test_wrap();
    ready = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) step();
    redirect_valid = 1'b1;
    redirect_addr  = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 20 && !out_valid; i++) step();
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 64'hFFFF_FFFF_FFFF_FFFF)
      begin miscompares++; $display("FAIL wrap_offer: valid=%0b pc=%h need 1 all-ones", out_valid, out_pc); end
    step();
    vectors++;
    if (icache_req !== 1'b1 || icache_addr !== 64'h0)
      begin miscompares++; $display("FAIL wrap_next: req=%0b addr=%h need 1 0", icache_req, icache_addr); end
  endtask

  task automatic test_reset_mid();
    delay_cfg = 5;
    ready = 1'b1;
    step();
    for (int i = 0; i < 20 && !icache_req; i++) step();
    step();
    rst = 1'b1;
    step();
    vectors++;
    if (out_valid !== 1'b0 || icache_req !== 1'b0)
      begin miscompares++; $display("FAIL mid_reset: valid=%0b req=%0b need 0 0", out_valid, icache_req); end
    rst = 1'b0;
    delay_cfg = 1;
    step();
    vectors++;
    if (icache_req !== 1'b1 || icache_addr !== RESET_PC)
      begin miscompares++; $display("FAIL mid_restart: req=%0b addr=%h need 1 %h", icache_req, icache_addr, RESET_PC); end
  endtask

  task automatic test_random();
    int start_offers;
    start_offers = offers;
    spurious_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      ready          = ($urandom_range(0, 9) < 7);
      delay_cfg      = $urandom_range(1, 4);
      redirect_valid = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) redirect_addr = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 2));
      else redirect_addr = {$urandom, $urandom};
      step();
    end
    redirect_valid = 1'b0;
    spurious_en = 1'b0;
    vectors++;
    if (offers - start_offers < 10)
      begin miscompares++; $display("FAIL random_progress: got %0d offers need >=10", offers - start_offers); end
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    cache_valid    = 1'b0;
    cache_instr    = '0;
    ready          = 1'b0;
    exp_next       = RESET_PC;
    req_addr       = '0;
    resp_word      = '0;
    live           = 1'b0;
    pending        = 1'b0;
    countdown      = 0;
    resp_real      = 1'b0;
    spurious_en    = 1'b0;
    force_en       = 1'b0;
    force_word     = '0;
    prev_valid     = 1'b0;
    prev_instr     = '0;
    prev_pc        = '0;
    test_reset();
    test_sequential();
    test_hit_latency();
    test_backpressure();
    test_redirect_miss();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
